mult_iter_signed: RTL and testbench

//  Parametrised iterative (radix-2 shift-add) multiplier with per-operation unsigned/signed mode.

---
 rtl/mult_iter_signed_pkg.sv | 21 ++
 rtl/mult_iter_signed_sign_mag.sv | 18 +
 rtl/mult_iter_signed.sv | 121 ++++++++++++
 tb/tb_mult_iter_signed.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_iter_signed_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_iter_signed_pkg;

  // Control states; encodings kept fixed so waveforms read the same across builds.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Product width: an A_W x B_W magnitude product never needs more than A_W+B_W bits.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Iteration counter width; must be able to hold B_W.
  function automatic int cnt_w(input int b_w);
    return (b_w < 1) ? 1 : $clog2(b_w + 1);
  endfunction

endpackage

// File: rtl/mult_iter_signed_sign_mag.sv
// Sign/magnitude split of one operand. Purely combinational.
// The magnitude of the most-negative value still fits in W unsigned bits.
module sign_mag_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  logic         is_signed,
  output logic [W-1:0] mag,
  output logic         sgn
);

  // Negative only when the operand is declared two's complement and its msb is set.
  always_comb begin
    sgn = is_signed & val[W-1];
    mag = sgn ? (~val + W'(1)) : val;
  end

endmodule

// File: rtl/mult_iter_signed.sv
// Iterative radix-2 multiplier: one multiplier bit per cycle, optional early
// exit once the remaining multiplier bits are all zero. Operands are converted
// to magnitudes on accept; the sign is re-applied when the result is registered.
module mult_iter_signed
  import mult_iter_signed_pkg::*;
#(
  parameter int A_W        = 16,
  parameter int B_W        = 9,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [A_W-1:0]                a,
  input  logic [B_W-1:0]                b,
  input  logic                          is_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [prod_w(A_W, B_W)-1:0]   p
);

  localparam int PW = prod_w(A_W, B_W);
  localparam int CW = cnt_w(B_W);

  state_t          state, state_nx;
  logic [A_W-1:0]  mag_a_in, mag_a;
  logic [B_W-1:0]  mag_b_in, mag_b;
  logic            sgn_a, sgn_b, neg;
  logic [PW-1:0]   acc, addend;
  logic [CW-1:0]   cnt;
  logic            accept, calc_last, out_hs;

  sign_mag_conv #(.W(A_W)) u_conv_a (
    .val       (a),
    .is_signed (is_signed),
    .mag       (mag_a_in),
    .sgn       (sgn_a)
  );

  sign_mag_conv #(.W(B_W)) u_conv_b (
    .val       (b),
    .is_signed (is_signed),
    .mag       (mag_b_in),
    .sgn       (sgn_b)
  );

  // Handshake decodes and the CALC termination condition.
  always_comb begin
    accept    = in_valid & in_ready;
    out_hs    = out_valid & out_ready;
    addend    = PW'(mag_a) << cnt;
    calc_last = (cnt == CW'(B_W - 1)) ||
                ((EARLY_EXIT != 0) && ((mag_b >> 1) == '0));
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic. DONE only releases after the output handshake, so a new
  // operand offered in the same cycle is taken one cycle later from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)    state_nx = ST_CALC;
      ST_CALC: if (calc_last) state_nx = ST_DONE;
      ST_DONE: if (out_hs)    state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // Datapath: operand capture, shift-add accumulation, result register.
  // The first DONE cycle loads p from the finished accumulator and raises
  // out_valid; both then hold until the downstream takes the product.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            neg   <= sgn_a ^ sgn_b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ST_CALC: begin
          if (mag_b[0]) acc <= acc + addend;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CW'(1);
        end
        ST_DONE: begin
          if (!out_valid) begin
            p         <= neg ? (~acc + PW'(1)) : acc;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_iter_signed.sv
// Bench for mult_iter_signed: two instances (EARLY_EXIT=0 and 1) with
// directed corner cases and randomized back-to-back traffic against a
// plain-arithmetic reference.
module tb_mult_iter_signed;

  logic        clk = 1'b0;
  logic [1:0]  sys_rst, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [15:0] a [2];
  logic [8:0]  b [2];
  logic [24:0] p [2];
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  logic [24:0] exp_q [$];
  int          lat_q [$];
  int          cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mult_iter_signed #(.A_W(16), .B_W(9), .EARLY_EXIT(g)) u_dut (
      .sys_clk   (clk),
      .sys_rst   (sys_rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .is_signed (is_signed[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .p         (p[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference product from ordinary integer multiplication.
  function automatic logic [24:0] ref_p(input logic [15:0] av, input logic [8:0] bv, input logic s);
    longint x, y;
    x = s ? longint'($signed(av)) : longint'(av);
    y = s ? longint'($signed(bv)) : longint'(bv);
    return 25'(x * y);
  endfunction

  // Reference latency: fixed 10, or bit length of |b| (min 1) plus one.
  function automatic int ref_lat(input int ee, input logic [8:0] bv, input logic s);
    int v, m, bl;
    v  = s ? int'($signed(bv)) : int'(bv);
    m  = (v < 0) ? -v : v;
    bl = 0;
    while (m > 0) begin bl++; m = m >> 1; end
    if (ee == 0) return 10;
    return ((bl < 1) ? 1 : bl) + 1;
  endfunction

  // One directed operation; optionally stalls out_ready for 'hold' cycles.
  task automatic run_op(input int d, input logic [15:0] av, input logic [8:0] bv,
                        input logic s, input int hold,
                        output logic [24:0] got, output int lat);
    int tmo;
    logic [24:0] p0;
    @(negedge clk);
    tmo = 0;
    while (!in_ready[d] && tmo < 50) begin @(negedge clk); tmo++; end
    chk("op_in_ready", 32'(in_ready[d]), 1);
    a[d] = av; b[d] = bv; is_signed[d] = s; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0; a[d] = 16'($urandom); b[d] = 9'($urandom); is_signed[d] = 1'($urandom);
    chk("op_busy", 32'(in_ready[d]), 0);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin @(negedge clk); lat++; end
    chk("op_out_valid", 32'(out_valid[d]), 1);
    got = p[d];
    p0  = p[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid[d]), 1);
      chk("hold_p", 32'(p[d]), 32'(p0));
      chk("hold_in_ready", 32'(in_ready[d]), 0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("post_valid", 32'(out_valid[d]), 0);
    chk("post_in_ready", 32'(in_ready[d]), 1);
  endtask

  task automatic drive_rand(input int d, input int n);
    int tmo, gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      a[d] = 16'($urandom); b[d] = 9'($urandom); is_signed[d] = 1'($urandom);
      in_valid[d] = 1'b1;
      tmo = 0;
      while (!in_ready[d] && tmo < 200) begin @(negedge clk); tmo++; end
      if (!in_ready[d]) begin
        chk("rnd_accept_tmo", 32'(in_ready[d]), 1);
        in_valid[d] = 1'b0;
        return;
      end
      exp_q.push_back(ref_p(a[d], b[d], is_signed[d]));
      lat_q.push_back(ref_lat(d, b[d], is_signed[d]));
      cyc_q.push_back(cyc);
      @(negedge clk);
      in_valid[d] = 1'b0; a[d] = 16'($urandom); b[d] = 9'($urandom);
    end
  endtask

  task automatic mon_rand(input int d, input int n);
    int got, budget, tf;
    bit seen;
    got = 0; budget = 0; tf = 0; seen = 0;
    while (got < n && budget < n * 40) begin
      @(negedge clk);
      budget++;
      out_ready[d] = 1'($urandom);
      if (out_valid[d] && !seen) begin seen = 1; tf = cyc; end
      if (out_valid[d] && out_ready[d]) begin
        chk("rnd_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("rnd_p", 32'(p[d]), 32'(exp_q.pop_front()));
          chk("rnd_lat", 32'(tf - cyc_q.pop_front() - 1), 32'(lat_q.pop_front()));
        end
        seen = 0;
        got++;
      end
    end
    chk("rnd_count", 32'(got), 32'(n));
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [24:0] r;
    int          l;
    sys_rst = 2'b11; in_valid = '0; is_signed = '0; out_ready = '0;
    for (int i = 0; i < 2; i++) begin a[i] = '0; b[i] = '0; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 1);
      chk("rst_out_valid", 32'(out_valid[d]), 0);
      chk("rst_p", 32'(p[d]), 0);
    end
    sys_rst = 2'b00;

    // Unsigned full-scale, fixed latency.
    run_op(0, 16'hFFFF, 9'h1FF, 1'b0, 0, r, l);
    chk("t1_p", 32'(r), 32'h1FEFE01);
    chk("t1_lat", 32'(l), 10);

    // Signed extremes on both variants.
    for (int d = 0; d < 2; d++) begin
      run_op(d, 16'h8000, 9'h100, 1'b1, 0, r, l);
      chk("t2_minmin", 32'(r), 32'h0800000);
      run_op(d, 16'hFFFF, 9'h001, 1'b1, 0, r, l);
      chk("t2_neg1", 32'(r), 32'h1FFFFFF);
    end

    // Early-exit latencies.
    run_op(1, 16'h1234, 9'h000, 1'b1, 0, r, l);
    chk("t3_b0_p", 32'(r), 0);
    chk("t3_b0_lat", 32'(l), 2);
    run_op(1, 16'h0003, 9'h004, 1'b0, 0, r, l);
    chk("t3_b4_p", 32'(r), 32'hC);
    chk("t3_b4_lat", 32'(l), 4);
    run_op(1, 16'hFFFF, 9'h1FF, 1'b0, 0, r, l);
    chk("t3_bff_p", 32'(r), 32'h1FEFE01);
    chk("t3_bff_lat", 32'(l), 10);
    run_op(0, 16'h0003, 9'h004, 1'b0, 0, r, l);
    chk("t3_noee_lat", 32'(l), 10);

    // Output back-pressure.
    run_op(1, 16'hF00D, 9'h0A5, 1'b1, 5, r, l);
    chk("t4_p", 32'(r), 32'(ref_p(16'hF00D, 9'h0A5, 1'b1)));

    // Reset in the middle of CALC.
    @(negedge clk);
    a[0] = 16'hABCD; b[0] = 9'h1FF; is_signed[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst[0] = 1'b1;
    @(negedge clk);
    sys_rst[0] = 1'b0;
    chk("t5_in_ready", 32'(in_ready[0]), 1);
    chk("t5_out_valid", 32'(out_valid[0]), 0);
    chk("t5_p", 32'(p[0]), 0);
    repeat (12) @(negedge clk);
    chk("t5_no_stale", 32'(out_valid[0]), 0);
    run_op(0, 16'h7FFF, 9'h0FF, 1'b1, 0, r, l);
    chk("t5_after_p", 32'(r), 32'(ref_p(16'h7FFF, 9'h0FF, 1'b1)));

    // Random back-to-back traffic with random back-pressure.
    for (int d = 0; d < 2; d++) begin
      exp_q.delete(); lat_q.delete(); cyc_q.delete();
      @(negedge clk);
      fork
        drive_rand(d, 1500);
        mon_rand(d, 1500);
      join
      chk("rnd_leftover", 32'(exp_q.size()), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
